equiv_sweep_checker: RTL and testbench
======================================

// Module: equiv_sweep_checker
// PURPOSE
//  Exhaustive stimulus-and-compare stage for the two implementations of the
//  4-input / 5-output logic block (dataflow and behavioral). It drives every
//  input vector 0..2**IN_W-1 to both models and waits SETTLE cycles per vector.
//  It then compares the packed outputs {o3,o2[1:0],o1,o0} of the two models and
//  reports a mismatch count, the first failing vector and a pass/done verdict.
//  It replaces the hand-written per-vector sequence with a self-checking sweep.
// PARAMETERS
//  IN_W   4  width of stimulus vector (packed {i3,i2,i1,i0})
//  OUT_W  5  width of packed model output {o3,o2[1:0],o1,o0}
//  SETTLE 2  cycles each vector is held before sampling; legal range >=1
//  CNT_W  8  mismatch counter width; counter saturates at all-ones
// PORTS
//  clk              in   1      rising-edge clock
//  rst_n            in   1      asynchronous active-low reset
//  start            in   1      1-cycle request to begin a sweep (level ok)
//  stim             out  IN_W   vector driven to both models, registered
//  out_a            in   OUT_W  packed outputs of model A (dataflow)
//  out_b            in   OUT_W  packed outputs of model B (behavioral)
//  busy             out  1      high from sweep start until DONE is entered
//  done             out  1      high while in DONE; held until next start
//  pass             out  1      valid when done=1: 1 iff mismatch_cnt==0
//  mismatch_cnt     out  CNT_W  number of vectors with out_a !== out_b
//  first_fail_valid out  1      set on the first mismatch of a sweep
//  first_fail_vec   out  IN_W   stim value at the first mismatch
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; stim=0, busy=0, done=0, pass=0,
//   mismatch_cnt=0, first_fail_valid=0, first_fail_vec=0, settle_cnt=0.
//  FSM states: IDLE, DRIVE, SAMPLE, DONE.
//  IDLE: start=1 at edge -> DRIVE. At the same edge: stim=0, settle_cnt=0,
//   mismatch_cnt=0, first_fail_valid=0, first_fail_vec=0, busy=1.
//  DRIVE: stim is held. settle_cnt increments each cycle. When
//   settle_cnt==SETTLE-1 -> SAMPLE and settle_cnt=0.
//  SAMPLE (exactly 1 cycle): compare out_a vs out_b with 4-state inequality;
//   X/Z on either side counts as a mismatch. On a mismatch, mismatch_cnt+1,
//   saturating at 2**CNT_W-1. On the first mismatch only: first_fail_vec=stim
//   and first_fail_valid=1.
//   If stim==all-ones -> DONE: busy=0, done=1, pass=(final count==0),
//   including a mismatch on the last vector.
//   Otherwise stim+1 (no wrap is possible) -> DRIVE.
//  DONE: all results held. start=1 -> behaves exactly as start in IDLE, so
//   done/pass clear and a new sweep begins.
//  start while busy=1 is ignored; the running sweep is unaffected.
//  Latency: the sweep takes (2**IN_W)*(SETTLE+1) edges from the start edge to
//   done=1. With defaults this is 48 cycles.
//  stim changes only on the SAMPLE->DRIVE edge, so the models see each vector
//   for exactly SETTLE+1 cycles.
//  Reset mid-sweep: all outputs return to reset values immediately; no
//   partial result is retained.
//  Outputs are registered; there is no combinational path from out_a/out_b
//   to any output.
// TESTING
//  1. out_b=out_a (identical models), pulse start -> done=1 exactly 48 cycles
//     later, pass=1, mismatch_cnt=0, first_fail_valid=0, stim=4'hF.
//  2. out_b=out_a^5'b00001 only when stim==4'h5 -> mismatch_cnt=1,
//     first_fail_vec=4'h5, first_fail_valid=1, pass=0.
//  3. out_b=~out_a always -> mismatch_cnt=16, first_fail_vec=0, pass=0.
//     Rerun with CNT_W=3 -> mismatch_cnt=7 (saturated).
//  4. Pulse start at cycles 10 and 30 of a sweep -> done still at cycle 48.
//     start in DONE -> done=0 next cycle, counters cleared, new 48-cycle run.
//  5. rst_n=0 at cycle 20 of a sweep -> all outputs 0 at once, no clock
//     needed. Release and start -> full 48-cycle sweep, correct result.
//  6. SETTLE=1 with out_a driven to X at stim==4'h9 -> done after 32 cycles,
//     mismatch_cnt=1, first_fail_vec=4'h9.

Source files
------------

// File: rtl/equiv_sweep_checker.sv
// equiv_sweep_checker
//   Exhaustive stimulus-and-compare stage for two implementations of the same
//   logic block. Every vector 0..2**IN_W-1 is driven to both models, held for
//   SETTLE cycles, then sampled for one cycle. The packed outputs of the two
//   models are compared with 4-state inequality. The stage reports:
//     - how many vectors mismatched
//     - the first failing vector
//     - a pass/done verdict
//
//   Ports:
//     clk              rising-edge clock
//     rst_n            asynchronous active-low reset
//     start            request to begin a sweep (ignored while busy)
//     stim             vector driven to both models (registered)
//     out_a            packed outputs of model A (dataflow)
//     out_b            packed outputs of model B (behavioral)
//     busy             high from sweep start until done
//     done             high once a sweep has finished, held until next start
//     pass             valid with done: 1 iff no mismatches were counted
//     mismatch_cnt     number of mismatching vectors, saturating
//     first_fail_valid set on the first mismatch of a sweep
//     first_fail_vec   stim value of the first mismatch
module equiv_sweep_checker #(
   parameter int IN_W   = 4,
   parameter int OUT_W  = 5,
   parameter int SETTLE = 2,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [IN_W-1:0]  stim,
   input  logic [OUT_W-1:0] out_a,
   input  logic [OUT_W-1:0] out_b,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] mismatch_cnt,
   output logic             first_fail_valid,
   output logic [IN_W-1:0]  first_fail_vec
);

   localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [SC_W-1:0] settle_cnt;
   logic            settle_last;
   logic            mism;
   logic            last_vec;
   logic [CNT_W-1:0] cnt_inc;

   // Case inequality, so that an X or Z on either model counts as a
   // mismatch instead of silently comparing equal.
   assign mism        = (out_a !== out_b);
   assign last_vec    = (stim == '1);
   assign settle_last = (settle_cnt == SC_W'(SETTLE - 1));

   // Count after this sample, saturating at all-ones. The final verdict
   // uses this value, so a mismatch on the last vector still fails.
   assign cnt_inc = (mism && (mismatch_cnt != '1)) ?
                    mismatch_cnt + CNT_W'(1) : mismatch_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE,
         S_DONE:   if (start) state_nx = S_DRIVE;
         S_DRIVE:  if (settle_last) state_nx = S_SAMPLE;
         S_SAMPLE: state_nx = last_vec ? S_DONE : S_DRIVE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stim             <= '0;
         settle_cnt       <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         mismatch_cnt     <= '0;
         first_fail_valid <= 1'b0;
         first_fail_vec   <= '0;
      end else begin
         case (state)
            S_IDLE,
            S_DONE: begin
               if (start) begin
                  stim             <= '0;
                  settle_cnt       <= '0;
                  busy             <= 1'b1;
                  done             <= 1'b0;
                  pass             <= 1'b0;
                  mismatch_cnt     <= '0;
                  first_fail_valid <= 1'b0;
                  first_fail_vec   <= '0;
               end
            end
            S_DRIVE: begin
               if (settle_last) settle_cnt <= '0;
               else             settle_cnt <= settle_cnt + SC_W'(1);
            end
            S_SAMPLE: begin
               mismatch_cnt <= cnt_inc;
               if (mism && !first_fail_valid) begin
                  first_fail_valid <= 1'b1;
                  first_fail_vec   <= stim;
               end
               if (last_vec) begin
                  busy <= 1'b0;
                  done <= 1'b1;
                  pass <= (cnt_inc == '0);
               end else begin
                  stim <= stim + IN_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_equiv_sweep_checker.sv
// tb_equiv_sweep_checker
//   Drives three checker instances:
//     - defaults
//     - CNT_W=3
//     - SETTLE=1
//   The two "models" are a stand-in logic function plus a per-vector fault
//   mask (and optional X injection). Expected results are computed directly
//   from the mask table.
module tb_equiv_sweep_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start    [3];
   logic [3:0] stim     [3];
   logic [4:0] out_a    [3];
   logic [4:0] out_b    [3];
   logic       busy     [3];
   logic       done     [3];
   logic       pass     [3];
   logic       ffv      [3];
   logic [3:0] ffvec    [3];
   logic [7:0] cnt0;
   logic [2:0] cnt1;
   logic [7:0] cnt2;

   logic [4:0] mask [16];
   logic [4:0] key;
   logic       xinj;
   logic [3:0] xvec;

   int tests = 0;
   int fails = 0;

   function automatic logic [4:0] blk(input logic [3:0] v);
      return {v[3] & v[2], v[2:1] ^ v[1:0], v[0] | v[3], ^v};
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_models
      assign out_a[g] = (xinj && stim[g] == xvec) ? 5'bxxxxx : (blk(stim[g]) ^ key);
      assign out_b[g] = blk(stim[g]) ^ key ^ mask[stim[g]];
   end

   equiv_sweep_checker u_def (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .stim(stim[0]),
      .out_a(out_a[0]), .out_b(out_b[0]), .busy(busy[0]), .done(done[0]),
      .pass(pass[0]), .mismatch_cnt(cnt0), .first_fail_valid(ffv[0]),
      .first_fail_vec(ffvec[0])
   );

   equiv_sweep_checker #(.CNT_W(3)) u_c3 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .stim(stim[1]),
      .out_a(out_a[1]), .out_b(out_b[1]), .busy(busy[1]), .done(done[1]),
      .pass(pass[1]), .mismatch_cnt(cnt1), .first_fail_valid(ffv[1]),
      .first_fail_vec(ffvec[1])
   );

   equiv_sweep_checker #(.SETTLE(1)) u_s1 (
      .clk(clk), .rst_n(rst_n), .start(start[2]), .stim(stim[2]),
      .out_a(out_a[2]), .out_b(out_b[2]), .busy(busy[2]), .done(done[2]),
      .pass(pass[2]), .mismatch_cnt(cnt2), .first_fail_valid(ffv[2]),
      .first_fail_vec(ffvec[2])
   );

   function automatic logic [7:0] cnt_of(input int k);
      case (k)
         0:       return cnt0;
         1:       return {5'b00000, cnt1};
         default: return cnt2;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("check %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input int k, input string tag);
      chk({tag, "_stim"}, 32'(stim[k]),  0);
      chk({tag, "_busy"}, 32'(busy[k]),  0);
      chk({tag, "_done"}, 32'(done[k]),  0);
      chk({tag, "_pass"}, 32'(pass[k]),  0);
      chk({tag, "_cnt"},  32'(cnt_of(k)), 0);
      chk({tag, "_ffv"},  32'(ffv[k]),   0);
      chk({tag, "_ffvec"}, 32'(ffvec[k]), 0);
   endtask

   task automatic rand_mask(input int density);
      for (int v = 0; v < 16; v++)
         mask[v] = ($urandom_range(0, density) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
   endtask

   // One full sweep on instance k; expectations derived from the mask table.
   task automatic run(input int k, input string tag, input bit pulses);
      int         settle;
      int         cmax;
      int         ecnt;
      int         n;
      bit         ehas;
      logic [3:0] efirst;
      settle = (k == 2) ? 1 : 2;
      cmax   = (k == 1) ? 7 : 255;
      ecnt   = 0;
      ehas   = 0;
      efirst = 4'h0;
      for (int v = 0; v < 16; v++) begin
         if (mask[v] != 5'd0 || (xinj && v == int'(xvec))) begin
            if (!ehas) begin
               ehas   = 1;
               efirst = 4'(v);
            end
            if (ecnt < cmax) ecnt++;
         end
      end

      @(posedge clk); #1 start[k] = 1'b1;
      @(posedge clk); #1 start[k] = 1'b0;
      chk({tag, "_go_done"}, 32'(done[k]), 0);
      chk({tag, "_go_busy"}, 32'(busy[k]), 1);
      chk({tag, "_go_cnt"},  32'(cnt_of(k)), 0);
      chk({tag, "_go_ffv"},  32'(ffv[k]), 0);
      chk({tag, "_go_stim"}, 32'(stim[k]), 0);

      n = 0;
      while (n < 400 && done[k] !== 1'b1) begin
         if (pulses && (n == 10 || n == 30)) start[k] = 1'b1;
         @(posedge clk); #1;
         start[k] = 1'b0;
         n++;
      end
      chk({tag, "_latency"}, 32'(n), 32'(16 * (settle + 1)));
      chk({tag, "_busy"},    32'(busy[k]), 0);
      chk({tag, "_pass"},    32'(pass[k]), 32'(ecnt == 0));
      chk({tag, "_cnt"},     32'(cnt_of(k)), 32'(ecnt));
      chk({tag, "_ffv"},     32'(ffv[k]), 32'(ehas));
      chk({tag, "_ffvec"},   32'(ffvec[k]), 32'(efirst));
      chk({tag, "_stim"},    32'(stim[k]), 32'hF);

      // Results must hold in the done state without a new start.
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_hold_done"}, 32'(done[k]), 1);
      chk({tag, "_hold_cnt"},  32'(cnt_of(k)), 32'(ecnt));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int k = 0; k < 3; k++) start[k] = 1'b0;
      for (int v = 0; v < 16; v++) mask[v] = 5'd0;
      key   = 5'($urandom_range(0, 31));
      xinj  = 1'b0;
      xvec  = 4'h0;
      rst_n = 1'b0;
      #12;
      for (int k = 0; k < 3; k++) chk_zero(k, "reset");
      @(posedge clk); #1 rst_n = 1'b1;

      // Identical models.
      run(0, "ident", 0);

      // Single fault on vector 5, low bit.
      mask[5] = 5'b00001;
      run(0, "vec5", 0);

      // Fully inverted output: every vector fails, and the narrow counter
      // saturates.
      for (int v = 0; v < 16; v++) mask[v] = 5'h1F;
      run(0, "inv", 0);
      run(1, "inv_sat", 0);

      // Start pulses while busy are ignored; start in done restarts.
      rand_mask(3);
      run(0, "busy_start", 1);
      rand_mask(2);
      run(0, "restart", 0);

      // Reset in the middle of a sweep clears everything asynchronously.
      rand_mask(1);
      @(posedge clk); #1 start[0] = 1'b1;
      @(posedge clk); #1 start[0] = 1'b0;
      repeat (19) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk_zero(0, "midrst");
      @(posedge clk); #1 rst_n = 1'b1;
      rand_mask(3);
      run(0, "after_rst", 0);

      // X on model A at vector 9, shorter settle.
      for (int v = 0; v < 16; v++) mask[v] = 5'd0;
      xinj = 1'b1;
      xvec = 4'h9;
      run(2, "xinj", 0);

      // Random sweeps across all three instances.
      for (int r = 0; r < 6; r++) begin
         rand_mask($urandom_range(0, 4));
         key  = 5'($urandom_range(0, 31));
         xinj = 1'($urandom_range(0, 1));
         xvec = 4'($urandom_range(0, 15));
         run(r % 3, "rand", 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
